// File: rtl/halut_pkg.sv
// -----------------------------------------------------------------------------
// halut_pkg
//   Shared definitions for the HALUT decoder/accumulator lane:
//   - default geometry (K prototypes, C codebooks, DataTypeWidth entry width)
//   - acc_width(): accumulator width that can hold C sign-extended entries
//     without overflow
//   - halut_dec_state_e: decoder/accumulator FSM states
// -----------------------------------------------------------------------------
package halut_pkg;

  // Default geometry; the decoder uses these as its parameter defaults.
  localparam int K             = 16;
  localparam int C             = 32;
  localparam int DataTypeWidth = 16;

  // A sum of c entries of dw bits needs dw + clog2(c) bits to never overflow.
  function automatic int acc_width(input int dw, input int c);
    return dw + $clog2(c);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } halut_dec_state_e;

endpackage

// File: rtl/halut_lut_mem.sv
// -----------------------------------------------------------------------------
// halut_lut_mem
//   C x K register file of DW-bit entries.
//   One write port and one synchronous read port. A read and a write to the
//   same entry on the same edge return the old contents (read-before-write).
//   All entries and the read register clear asynchronously on rst_i.
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   we_i                    write strobe
//   waddr_c_i, waddr_k_i    write codebook / prototype index
//   wdata_i                 write data
//   re_i                    read enable (read register holds when low)
//   raddr_c_i, raddr_k_i    read codebook / prototype index
//   rdata_o                 read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module halut_lut_mem #(
  parameter int K  = 16,
  parameter int C  = 32,
  parameter int DW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [$clog2(C)-1:0] waddr_c_i,
  input  logic [$clog2(K)-1:0] waddr_k_i,
  input  logic [DW-1:0]        wdata_i,
  input  logic                 re_i,
  input  logic [$clog2(C)-1:0] raddr_c_i,
  input  logic [$clog2(K)-1:0] raddr_k_i,
  output logic [DW-1:0]        rdata_o
);

  logic [DW-1:0] r_mem [C][K];
  logic [DW-1:0] r_rdata;

  // Both the read and the write use non-blocking updates on the same edge,
  // so a colliding read naturally samples the pre-write value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < C; c++) begin
        for (int k = 0; k < K; k++) begin
          r_mem[c][k] <= '0;
        end
      end
      r_rdata <= '0;
    end else begin
      if (we_i) begin
        r_mem[waddr_c_i][waddr_k_i] <= wdata_i;
      end
      if (re_i) begin
        r_rdata <= r_mem[raddr_c_i][raddr_k_i];
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/halut_decoder_acc.sv
// -----------------------------------------------------------------------------
// halut_decoder_acc
//   Decoder/accumulator lane for the HALUT datapath. Holds a C x K table of
//   signed entries. A row is a stream of encoded prototype indices, one per
//   codebook in beat order (codebook index is implicit). The lane sums
//   LUT[c][k] over num_c codebooks and presents the saturated and full-width
//   sums on a result handshake.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid and ready are both high. enc_ready_o and res_valid_o are registered
//   decodes of the FSM and never depend combinationally on any input. A
//   source must hold valid and its payload until the transfer; res_* outputs
//   hold steady while res_valid_o is high and res_ready_i is low.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   lut_we_i, lut_waddr_c_i,
//   lut_waddr_k_i, lut_wdata_i         LUT write port (any state)
//   cfg_num_c_i                        codebooks per row, sampled on beat 0
//                                      (0 or > C means C)
//   enc_valid_i, enc_ready_o, enc_k_i  encoded beat stream
//   res_valid_o, res_ready_i           result handshake
//   res_data_o                         sum clamped to DataTypeWidth
//   res_acc_o                          unclamped sum
//   res_sat_o                          res_data_o was clamped
//   dbg_state_o                        current FSM state (halut_dec_state_e)
// -----------------------------------------------------------------------------
module halut_decoder_acc #(
  parameter int K             = halut_pkg::K,
  parameter int C             = halut_pkg::C,
  parameter int DataTypeWidth = halut_pkg::DataTypeWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                lut_we_i,
  input  logic [$clog2(C)-1:0]                lut_waddr_c_i,
  input  logic [$clog2(K)-1:0]                lut_waddr_k_i,
  input  logic [DataTypeWidth-1:0]            lut_wdata_i,
  input  logic [$clog2(C):0]                  cfg_num_c_i,
  input  logic                                enc_valid_i,
  output logic                                enc_ready_o,
  input  logic [$clog2(K)-1:0]                enc_k_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [DataTypeWidth-1:0]            res_data_o,
  output logic [DataTypeWidth+$clog2(C)-1:0]  res_acc_o,
  output logic                                res_sat_o,
  output logic [1:0]                          dbg_state_o
);

  import halut_pkg::*;

  localparam int CW       = $clog2(C);
  localparam int KW       = $clog2(K);
  localparam int DW       = DataTypeWidth;
  localparam int AccWidth = acc_width(DataTypeWidth, C);
  localparam int AW       = AccWidth;

  localparam logic [CW:0] C_MAX = (CW+1)'(C);
  localparam logic [CW:0] C_ONE = (CW+1)'(1);

  // Clamp bounds expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  halut_dec_state_e       r_state;
  halut_dec_state_e       w_state_nxt;
  logic [CW:0]            r_num_c;
  logic [CW:0]            r_cnt;
  logic signed [AW-1:0]   r_acc;
  logic                   r_pend;      // a LUT read issued last cycle is due
  logic                   r_enc_ready;
  logic [DW-1:0]          r_res_data;
  logic [AW-1:0]          r_res_acc;
  logic                   r_res_sat;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic                   w_accept;
  logic [CW:0]            w_cfg_num_c;
  logic                   w_last_beat;
  logic [CW-1:0]          w_raddr_c;
  logic [DW-1:0]          w_lut_rdata;
  logic signed [AW-1:0]   w_rd_ext;
  logic signed [AW-1:0]   w_acc_sum;
  logic                   w_sat_hi;
  logic                   w_sat_lo;
  logic [DW-1:0]          w_sat_data;

  assign w_accept = enc_valid_i & r_enc_ready;

  // Out-of-range configurations collapse to a full row.
  assign w_cfg_num_c = ((cfg_num_c_i == '0) || (cfg_num_c_i > C_MAX)) ? C_MAX : cfg_num_c_i;

  // r_cnt is the codebook index of the beat being presented in ACCUM.
  assign w_last_beat = (r_cnt == (r_num_c - C_ONE));

  // The first beat of a row is always codebook 0, regardless of r_cnt.
  assign w_raddr_c = (r_state == IDLE) ? '0 : r_cnt[CW-1:0];

  halut_lut_mem #(
    .K  (K),
    .C  (C),
    .DW (DW)
  ) u_lut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (lut_we_i),
    .waddr_c_i (lut_waddr_c_i),
    .waddr_k_i (lut_waddr_k_i),
    .wdata_i   (lut_wdata_i),
    .re_i      (w_accept),
    .raddr_c_i (w_raddr_c),
    .raddr_k_i (enc_k_i),
    .rdata_o   (w_lut_rdata)
  );

  // The read data lags its address by one cycle; it is folded in on the
  // cycle after the beat that requested it.
  assign w_rd_ext  = {{(AW-DW){w_lut_rdata[DW-1]}}, w_lut_rdata};
  assign w_acc_sum = r_pend ? (r_acc + w_rd_ext) : r_acc;

  assign w_sat_hi   = (w_acc_sum > SAT_HI);
  assign w_sat_lo   = (w_acc_sum < SAT_LO);
  assign w_sat_data = w_sat_hi ? {1'b0, {(DW-1){1'b1}}} :
                      w_sat_lo ? {1'b1, {(DW-1){1'b0}}} :
                                 w_acc_sum[DW-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_cfg_num_c == C_ONE) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = OUT;
      end
      OUT: begin
        if (res_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_num_c     <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_pend      <= 1'b0;
      r_enc_ready <= 1'b0;
      r_res_data  <= '0;
      r_res_acc   <= '0;
      r_res_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // Ready is decoded from the next state so it is a plain flop output.
      r_enc_ready <= (w_state_nxt == IDLE) || (w_state_nxt == ACCUM);

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_num_c <= w_cfg_num_c;
            r_acc   <= '0;
            r_cnt   <= C_ONE;
            r_pend  <= 1'b1;
          end
        end
        ACCUM: begin
          r_acc  <= w_acc_sum;
          r_pend <= w_accept;
          if (w_accept) begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        DRAIN: begin
          // Last read lands here; capture the final result directly.
          r_acc      <= w_acc_sum;
          r_pend     <= 1'b0;
          r_res_acc  <= w_acc_sum;
          r_res_data <= w_sat_data;
          r_res_sat  <= w_sat_hi | w_sat_lo;
        end
        OUT: begin
          // Hold everything until the result is taken.
        end
        default: begin
          r_pend <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign enc_ready_o = r_enc_ready;
  assign res_valid_o = (r_state == OUT);
  assign res_data_o  = r_res_data;
  assign res_acc_o   = r_res_acc;
  assign res_sat_o   = r_res_sat;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_halut_decoder_acc.sv
// -----------------------------------------------------------------------------
// tb_halut_decoder_acc
//   Self-checking bench for halut_decoder_acc. A reference table mirrors the
//   LUT contents; each row's expected sum is the plain arithmetic sum of the
//   table entries selected by the beats, clamped to 16 bits for res_data_o.
// -----------------------------------------------------------------------------
module tb_halut_decoder_acc;

  localparam int K  = 16;
  localparam int C  = 32;
  localparam int DW = 16;
  localparam int CW = 5;
  localparam int KW = 4;
  localparam int AW = DW + CW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          lut_we_i = 1'b0;
  logic [CW-1:0] lut_waddr_c_i = '0;
  logic [KW-1:0] lut_waddr_k_i = '0;
  logic [DW-1:0] lut_wdata_i = '0;
  logic [CW:0]   cfg_num_c_i = '0;
  logic          enc_valid_i = 1'b0;
  logic          enc_ready_o;
  logic [KW-1:0] enc_k_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [DW-1:0] res_data_o;
  logic [AW-1:0] res_acc_o;
  logic          res_sat_o;
  logic [1:0]    dbg_state_o;

  halut_decoder_acc #(.K(K), .C(C), .DataTypeWidth(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .lut_we_i      (lut_we_i),
    .lut_waddr_c_i (lut_waddr_c_i),
    .lut_waddr_k_i (lut_waddr_k_i),
    .lut_wdata_i   (lut_wdata_i),
    .cfg_num_c_i   (cfg_num_c_i),
    .enc_valid_i   (enc_valid_i),
    .enc_ready_o   (enc_ready_o),
    .enc_k_i       (enc_k_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_data_o    (res_data_o),
    .res_acc_o     (res_acc_o),
    .res_sat_o     (res_sat_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int            model_lut [C][K];
  logic [AW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic model_clear();
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++)
        model_lut[c][k] = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic lut_write(input int c, input int k, input int v);
    @(negedge clk);
    lut_we_i      = 1'b1;
    lut_waddr_c_i = c[CW-1:0];
    lut_waddr_k_i = k[KW-1:0];
    lut_wdata_i   = v[DW-1:0];
    @(posedge clk);
    #1;
    lut_we_i = 1'b0;
    model_lut[c][k] = v;
  endtask

  task automatic lut_randomize();
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++)
        lut_write(c, k, int'($urandom_range(0, 65535)) - 32768);
  endtask

  // Drives n beats of a row (kfix < 0 picks random k). Beat number coll_beat
  // also writes coll_val to LUT[coll_c][coll_k] in the same cycle. Returns
  // at #1 after the edge that took the last beat.
  task automatic send_beats(input int n, input int cfg, input int kfix,
                            input int gap_max, input bit push,
                            input int coll_beat, input int coll_c,
                            input int coll_k, input int coll_val);
    int sum;
    int k;
    int w;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          enc_valid_i = 1'b0;
        end
      end
      @(negedge clk);
      k = (kfix >= 0) ? kfix : int'($urandom_range(0, K-1));
      enc_valid_i = 1'b1;
      enc_k_i     = k[KW-1:0];
      cfg_num_c_i = cfg[CW:0];
      w = 0;
      while (enc_ready_o !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      n_checks++;
      if (enc_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL beat_ready: beat %0d ready=%b, required 1 within 20 cycles", i, enc_ready_o);
        enc_valid_i = 1'b0;
        return;
      end
      if (i == coll_beat) begin
        lut_we_i      = 1'b1;
        lut_waddr_c_i = coll_c[CW-1:0];
        lut_waddr_k_i = coll_k[KW-1:0];
        lut_wdata_i   = coll_val[DW-1:0];
      end
      sum += model_lut[i][k];
      @(posedge clk);
      #1;
      enc_valid_i = 1'b0;
      lut_we_i    = 1'b0;
      if (i == coll_beat) model_lut[coll_c][coll_k] = coll_val;
    end
    if (push) exp_q.push_back(sum[AW-1:0]);
  endtask

  // Checks DRAIN then OUT timing, the result, stability for 'hold' cycles
  // with res_ready low, then completes the handshake. With poke set, valid is
  // held high during DRAIN/OUT to show no beat is taken there.
  task automatic finish_row(input int hold, input bit poke);
    logic [AW-1:0] e_acc;
    int            e_int;
    int            e_clip;
    logic [DW-1:0] e_data;
    logic          e_sat;
    @(negedge clk);
    if (poke) begin
      enc_valid_i = 1'b1;
      enc_k_i     = KW'($urandom_range(0, K-1));
    end
    n_checks++;
    if (res_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_valid: res_valid=%b, required 0 one cycle after last beat", res_valid_o);
    end
    n_checks++;
    if (enc_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_ready: enc_ready=%b, required 0", enc_ready_o);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_valid: res_valid=%b, required 1 two cycles after last beat", res_valid_o);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: queue empty, required one expected result");
      return;
    end
    e_acc  = exp_q.pop_front();
    e_int  = $signed(e_acc);
    e_clip = (e_int > 32767) ? 32767 : (e_int < -32768) ? -32768 : e_int;
    e_sat  = (e_clip != e_int);
    e_data = e_clip[DW-1:0];
    if (res_acc_o !== e_acc) begin
      n_fail++;
      $display("FAIL res_acc: got %0d, required %0d", $signed(res_acc_o), e_int);
    end
    n_checks++;
    if (res_data_o !== e_data) begin
      n_fail++;
      $display("FAIL res_data: got %0d, required %0d", $signed(res_data_o), e_clip);
    end
    n_checks++;
    if (res_sat_o !== e_sat) begin
      n_fail++;
      $display("FAIL res_sat: got %b, required %b", res_sat_o, e_sat);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid_o !== 1'b1 || res_acc_o !== e_acc || res_data_o !== e_data ||
          res_sat_o !== e_sat || enc_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d valid=%b acc=%0d data=%0d sat=%b ready=%b, required 1/%0d/%0d/%b/0",
                 h, res_valid_o, $signed(res_acc_o), $signed(res_data_o), res_sat_o, enc_ready_o,
                 e_int, e_clip, e_sat);
      end
    end
    @(negedge clk);
    res_ready_i = 1'b1;
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    enc_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (res_valid_o !== 1'b0 || enc_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake: valid=%b ready=%b, required 0/1", res_valid_o, enc_ready_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (enc_ready_o !== 1'b0 || res_valid_o !== 1'b0 || res_data_o !== '0 ||
        res_acc_o !== '0 || res_sat_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%0d acc=%0d sat=%b, required all 0",
               enc_ready_o, res_valid_o, res_data_o, res_acc_o, res_sat_o);
    end
    rst_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    n_checks++;
    if (enc_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: ready=%b valid=%b, required 1/0", enc_ready_o, res_valid_o);
    end
  endtask

  task automatic test_full_row();
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++)
        lut_write(c, k, c + k);
    send_beats(32, 0, 3, 0, 1'b1, -1, 0, 0, 0);
    n_checks++;
    if (exp_q[$] !== AW'(592)) begin
      n_fail++;
      $display("FAIL full_row_model: model sum %0d, required 592", exp_q[$]);
    end
    finish_row(0, 1'b0);
  endtask

  task automatic test_pos_sat();
    for (int c = 0; c < 4; c++) lut_write(c, 7, 32767);
    send_beats(4, 4, 7, 3, 1'b1, -1, 0, 0, 0);
    finish_row(5, 1'b0);
  endtask

  task automatic test_neg_single();
    lut_write(0, 9, -32768);
    send_beats(1, 1, 9, 0, 1'b1, -1, 0, 0, 0);
    finish_row(0, 1'b0);
  endtask

  task automatic test_collision();
    lut_write(0, 5, 1);
    lut_write(1, 5, 2);
    lut_write(2, 5, 10);
    lut_write(3, 5, 3);
    send_beats(4, 4, 5, 0, 1'b1, 2, 2, 5, 20);
    finish_row(1, 1'b0);
    send_beats(4, 4, 5, 0, 1'b1, -1, 0, 0, 0);
    finish_row(0, 1'b0);
  endtask

  task automatic test_reset_mid_row();
    for (int c = 0; c < 16; c++) lut_write(c, 0, 1);
    send_beats(7, 16, 0, 0, 1'b0, -1, 0, 0, 0);
    @(negedge clk);
    rst_i = 1'b1;
    model_clear();
    @(negedge clk);
    n_checks++;
    if (enc_ready_o !== 1'b0 || res_valid_o !== 1'b0 || res_acc_o !== '0) begin
      n_fail++;
      $display("FAIL midrow_reset: ready=%b valid=%b acc=%0d, required 0/0/0",
               enc_ready_o, res_valid_o, res_acc_o);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    // Table was cleared: a short row must sum to zero.
    send_beats(2, 2, -1, 0, 1'b1, -1, 0, 0, 0);
    finish_row(0, 1'b0);
    for (int c = 0; c < 16; c++) lut_write(c, 0, 1);
    send_beats(16, 16, 0, 0, 1'b1, -1, 0, 0, 0);
    finish_row(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    lut_randomize();
    send_beats(32, 40, -1, 0, 1'b1, -1, 0, 0, 0);
    finish_row(0, 1'b1);
    send_beats(32, 40, -1, 0, 1'b1, -1, 0, 0, 0);
    finish_row(2, 1'b1);
  endtask

  task automatic test_random_rows();
    int cfg;
    int n;
    for (int r = 0; r < 8; r++) begin
      cfg = int'($urandom_range(0, 63));
      n   = (cfg == 0 || cfg > C) ? C : cfg;
      send_beats(n, cfg, -1, 2, 1'b1, -1, 0, 0, 0);
      finish_row(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    model_clear();
    test_reset();
    test_full_row();
    test_pos_sat();
    test_neg_single();
    test_collision();
    test_reset_mid_row();
    test_back_to_back();
    test_random_rows();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
